// File: rtl/spi_frame_sequencer_if.sv
// FIFO read port, SPI pins and read-response bundle of the frame sequencer.
interface spi_frame_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 41
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  rsp_valid;
    logic [7:0]            rsp_addr;
    logic [31:0]           rsp_data;

    // Sequencer side.
    modport master (
        input  fifo_empty, fifo_rd_data, spi_miso,
        output fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi, rsp_valid, rsp_addr, rsp_data
    );

    // FIFO / SPI slave / response consumer side.
    modport slave (
        output fifo_empty, fifo_rd_data, spi_miso,
        input  fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi, rsp_valid, rsp_addr, rsp_data
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Read-side command FIFO sequencer: pops one 41-bit entry per frame and
// serialises it as an SPI mode-0 frame; read commands return 32 MISO bits.
module spi_frame_sequencer #(
    parameter int unsigned DATA_WIDTH = 41,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  enable,
    spi_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);
    typedef enum logic [2:0] {IDLE, POP, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [6:0] HALF_LAST = 7'd81;   // 41 bits x 2 SCLK halves
    localparam logic [5:0] CMD_BITS  = 6'd9;    // rw + addr, not captured from MISO

    state_t                state;
    state_t                state_next;
    logic [7:0]            div_cnt;
    logic [6:0]            half_cnt;
    logic [DATA_WIDTH-1:0] shreg;      // bits still to be sent after the one on mosi
    logic                  rw_q;
    logic [7:0]            addr_q;
    logic [31:0]           rx_shreg;
    logic                  sclk_q;
    logic                  cs_n_q;
    logic                  mosi_q;
    logic                  rsp_valid_q;
    logic [7:0]            rsp_addr_q;
    logic [31:0]           rsp_data_q;
    logic                  div_last;

    assign div_last       = (div_cnt == DIV_LAST);
    assign busy           = (state != IDLE);
    assign bus.fifo_rd_en = (state == POP);
    assign bus.spi_sclk   = sclk_q;
    assign bus.spi_cs_n   = cs_n_q;
    assign bus.spi_mosi   = mosi_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_addr   = rsp_addr_q;
    assign bus.rsp_data   = rsp_data_q;

    // State register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state decode; enable and fifo_empty only matter in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && !bus.fifo_empty) state_next = POP;
            POP:     state_next = LOAD;
            LOAD:    state_next = SETUP;
            SETUP:   if (div_last) state_next = SHIFT;
            SHIFT:   if (div_last && half_cnt == HALF_LAST) state_next = HOLD;
            HOLD:    if (div_last) state_next = GAP;
            GAP:     if (div_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase timers: div_cnt times each phase and each SCLK half, half_cnt indexes halves.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else begin
            if (state_next != state || state == IDLE || (state == SHIFT && div_last))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 8'd1;
            if (state == LOAD)
                half_cnt <= '0;
            else if (state == SHIFT && div_last)
                half_cnt <= half_cnt + 7'd1;
        end
    end

    // SPI pin flops and the transmit/receive shift registers.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            shreg    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            rx_shreg <= '0;
        end else begin
            cs_n_q <= !(state_next inside {SETUP, SHIFT, HOLD});
            case (state)
                LOAD: begin
                    rw_q   <= bus.fifo_rd_data[DATA_WIDTH-1];
                    addr_q <= bus.fifo_rd_data[DATA_WIDTH-2 -: 8];
                    mosi_q <= bus.fifo_rd_data[DATA_WIDTH-1];
                    // Pre-shifted by one: bit 40 is already on mosi. Reads send zero data.
                    if (bus.fifo_rd_data[DATA_WIDTH-1])
                        shreg <= {bus.fifo_rd_data[DATA_WIDTH-2:0], 1'b0};
                    else
                        shreg <= {bus.fifo_rd_data[DATA_WIDTH-2:32], 33'h0};
                end
                SHIFT: begin
                    if (div_last) begin
                        if (!half_cnt[0]) begin
                            sclk_q <= 1'b1;
                            if (half_cnt[6:1] >= CMD_BITS)
                                rx_shreg <= {rx_shreg[30:0], bus.spi_miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (half_cnt != HALF_LAST) begin
                                mosi_q <= shreg[DATA_WIDTH-1];
                                shreg  <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: if (div_last) mosi_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Frame completion: count every frame, publish read responses.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            frame_cnt   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state == HOLD && div_last) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (!rw_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= addr_q;
                    rsp_data_q  <= rx_shreg;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer (CLK_DIV=2, CS_GAP=2).
`timescale 1ns/1ps
module tb_spi_frame_sequencer;
    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        enable;
    logic        busy;
    logic [15:0] frame_cnt;

    spi_frame_sequencer_if #(.DATA_WIDTH(41)) bus ();

    spi_frame_sequencer #(.DATA_WIDTH(41), .CLK_DIV(2), .CS_GAP(2)) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .enable    (enable),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: show-ahead-free, data valid the cycle after the pop.
    logic [40:0] fifo_mem [16];
    logic [4:0]  wr_ptr = 5'd0;
    logic [4:0]  rd_ptr = 5'd0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read port.
    always @(posedge rd_clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= fifo_mem[rd_ptr[3:0]];
            rd_ptr           <= rd_ptr + 5'd1;
        end
    end

    // Monitor and SPI slave model, sampled on the falling clock edge.
    int          cyc = 0, rd_en_hi = 0, rsp_hi = 0, busy_hi = 0, frames_seen = 0;
    int          rises_cur = 0, last_rises = 0, cs_low_cur = 0, last_cs_low = 0;
    int          cs_high_cur = 0, last_cs_high = 0, cs_rise_cyc = 0, rsp_cyc = 0, sclk_idle_hi = 0;
    int          rd_times[$];
    logic [40:0] mosi_cur = '0, last_mosi = '0;
    logic [7:0]  rsp_addr_seen = '0;
    logic [31:0] rsp_data_seen = '0;
    logic [31:0] slave_word = '0;
    logic [31:0] miso_tmp;
    logic        sclk_prev = 1'b0, cs_prev = 1'b1;

    always @(negedge rd_clk) begin
        cyc++;
        if (bus.fifo_rd_en) begin
            rd_times.push_back(cyc);
            rd_en_hi++;
        end
        if (busy) busy_hi++;
        if (bus.rsp_valid) begin
            rsp_hi++;
            rsp_cyc       = cyc;
            rsp_addr_seen = bus.rsp_addr;
            rsp_data_seen = bus.rsp_data;
        end
        if (!bus.spi_cs_n) begin
            if (cs_prev) begin
                last_cs_high = cs_high_cur;
                cs_low_cur   = 0;
                rises_cur    = 0;
                mosi_cur     = '0;
            end
            cs_low_cur++;
            if (bus.spi_sclk && !sclk_prev) begin
                rises_cur++;
                mosi_cur = {mosi_cur[39:0], bus.spi_mosi};
            end
        end else begin
            if (!cs_prev) begin
                last_cs_low = cs_low_cur;
                last_rises  = rises_cur;
                last_mosi   = mosi_cur;
                cs_rise_cyc = cyc;
                cs_high_cur = 0;
                frames_seen++;
            end
            cs_high_cur++;
            if (bus.spi_sclk) sclk_idle_hi++;
        end
        sclk_prev = bus.spi_sclk;
        cs_prev   = bus.spi_cs_n;
        // Present data bit k (k = rising edges so far) before the next rise; command bits get 1s.
        if (rises_cur >= 9 && rises_cur <= 40) begin
            miso_tmp     = slave_word >> (40 - rises_cur);
            bus.spi_miso = miso_tmp[0];
        end else begin
            bus.spi_miso = 1'b1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge rd_clk);
            #1;
        end
    endtask

    task automatic push(input logic [40:0] e);
        fifo_mem[wr_ptr[3:0]] = e;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            tick(1);
            n++;
        end
        check({name, " frame done"}, 64'(frames_seen), 64'(target));
    endtask

    task automatic wait_bit(input int bitn, input int budget, input string name);
        int n = 0;
        while (!(bus.spi_cs_n == 1'b0 && rises_cur >= bitn) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, " reached bit"}, 64'(n < budget), 64'd1);
    endtask

    typedef struct {
        logic [40:0] entry;
        logic [31:0] miso_word;
        logic [40:0] exp_mosi;
        logic        exp_rsp;
        logic [7:0]  exp_addr;   // rsp_addr after the frame (held across writes)
        logic [31:0] exp_data;   // rsp_data after the frame
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, rb, sb, exp_frames, k;

        vecs[0] = '{41'h13CDEADBEEF, 32'hFFFF0000, 41'h13CDEADBEEF, 1'b0, 8'h00, 32'h00000000};
        vecs[1] = '{41'h0A5CAFEF00D, 32'h12345678, 41'h0A500000000, 1'b1, 8'hA5, 32'h12345678};
        vecs[2] = '{41'h10000000001, 32'h00000000, 41'h10000000001, 1'b0, 8'hA5, 32'h12345678};
        vecs[3] = '{41'h0FFFFFFFFFF, 32'h80000001, 41'h0FF00000000, 1'b1, 8'hFF, 32'h80000001};

        // Reset values.
        rd_rst_n = 1'b0;
        enable   = 1'b1;
        tick(3);
        check("rst cs_n", bus.spi_cs_n, 1'b1);
        check("rst sclk", bus.spi_sclk, 1'b0);
        check("rst mosi", bus.spi_mosi, 1'b0);
        check("rst rd_en", bus.fifo_rd_en, 1'b0);
        check("rst rsp_valid", bus.rsp_valid, 1'b0);
        check("rst rsp_addr", bus.rsp_addr, 8'h00);
        check("rst rsp_data", bus.rsp_data, 32'h0);
        check("rst busy", busy, 1'b0);
        check("rst frame_cnt", frame_cnt, 16'h0);

        // Enabled with an empty FIFO: nothing may happen.
        rd_rst_n = 1'b1;
        tick(50);
        check("empty rd_en pulses", 64'(rd_en_hi), 64'd0);
        check("empty busy cycles", 64'(busy_hi), 64'd0);
        check("empty frames", 64'(frames_seen), 64'd0);
        check("empty sclk high", 64'(sclk_idle_hi), 64'd0);

        // Single frames from the vector table.
        exp_frames = 0;
        for (int i = 0; i < 4; i++) begin
            fb = frames_seen;
            rb = rd_en_hi;
            sb = rsp_hi;
            slave_word = vecs[i].miso_word;
            push(vecs[i].entry);
            wait_frames(fb + 1, 400, $sformatf("v%0d", i));
            tick(4);
            exp_frames++;
            check($sformatf("v%0d rd_en pulses", i), 64'(rd_en_hi - rb), 64'd1);
            check($sformatf("v%0d cs_n low", i), 64'(last_cs_low), 64'd168);
            check($sformatf("v%0d sclk rises", i), 64'(last_rises), 64'd41);
            check($sformatf("v%0d mosi", i), 64'(last_mosi), 64'(vecs[i].exp_mosi));
            check($sformatf("v%0d rsp pulses", i), 64'(rsp_hi - sb), 64'(vecs[i].exp_rsp));
            if (vecs[i].exp_rsp) begin
                check($sformatf("v%0d rsp at cs rise", i), 64'(rsp_cyc), 64'(cs_rise_cyc));
                check($sformatf("v%0d rsp_addr strobe", i), 64'(rsp_addr_seen), 64'(vecs[i].exp_addr));
                check($sformatf("v%0d rsp_data strobe", i), 64'(rsp_data_seen), 64'(vecs[i].exp_data));
            end
            check($sformatf("v%0d rsp_addr held", i), 64'(bus.rsp_addr), 64'(vecs[i].exp_addr));
            check($sformatf("v%0d rsp_data held", i), 64'(bus.rsp_data), 64'(vecs[i].exp_data));
            check($sformatf("v%0d frame_cnt", i), 64'(frame_cnt), 64'(exp_frames));
            check($sformatf("v%0d busy idle", i), 64'(busy), 64'd0);
        end

        // Back-to-back: POP-to-POP = 3 + CS_GAP + 84*CLK_DIV = 173;
        // cs_n high between frames spans GAP + IDLE + POP + LOAD = 5.
        fb = frames_seen;
        rb = rd_en_hi;
        k  = rd_times.size();
        slave_word = 32'h0;
        push(41'h11111111111);
        push(41'h12222222222);
        push(41'h13333333333);
        wait_frames(fb + 3, 700, "b2b");
        tick(4);
        exp_frames += 3;
        check("b2b rd_en pulses", 64'(rd_en_hi - rb), 64'd3);
        check("b2b spacing 1", 64'(rd_times[k+1] - rd_times[k]), 64'd173);
        check("b2b spacing 2", 64'(rd_times[k+2] - rd_times[k+1]), 64'd173);
        check("b2b cs_n high gap", 64'(last_cs_high), 64'd5);
        check("b2b last mosi", 64'(last_mosi), 64'h13333333333);
        check("b2b frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // enable dropped mid-frame with two entries still queued.
        fb = frames_seen;
        rb = rd_en_hi;
        push(41'h1D0D0D0D0D0);
        push(41'h1E0E0E0E0E0);
        push(41'h1F0F0F0F0F0);
        wait_bit(20, 200, "en drop");
        enable = 1'b0;
        wait_frames(fb + 1, 300, "en drop");
        tick(300);
        exp_frames++;
        check("en drop rd_en pulses", 64'(rd_en_hi - rb), 64'd1);
        check("en drop frames", 64'(frames_seen - fb), 64'd1);
        check("en drop mosi", 64'(last_mosi), 64'h1D0D0D0D0D0);
        check("en drop busy", 64'(busy), 64'd0);
        check("en drop fifo left", 64'(wr_ptr - rd_ptr), 64'd2);
        check("en drop frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        enable = 1'b1;
        wait_frames(fb + 2, 400, "re-enable");
        check("re-enable mosi", 64'(last_mosi), 64'h1E0E0E0E0E0);
        wait_frames(fb + 3, 400, "re-enable 2");
        tick(4);
        exp_frames += 2;
        check("re-enable mosi 2", 64'(last_mosi), 64'h1F0F0F0F0F0);
        check("re-enable frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // Asynchronous reset in the middle of a read.
        sb = rsp_hi;
        slave_word = 32'hA5A5A5A5;
        push(41'h05A00000000);
        wait_bit(30, 300, "mid rst");
        #2;
        rd_rst_n = 1'b0;
        #1;
        check("mid rst cs_n", bus.spi_cs_n, 1'b1);
        check("mid rst sclk", bus.spi_sclk, 1'b0);
        check("mid rst mosi", bus.spi_mosi, 1'b0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst rd_en", bus.fifo_rd_en, 1'b0);
        check("mid rst rsp_valid", bus.rsp_valid, 1'b0);
        check("mid rst rsp_addr", bus.rsp_addr, 8'h00);
        check("mid rst rsp_data", bus.rsp_data, 32'h0);
        check("mid rst frame_cnt", frame_cnt, 16'h0);
        tick(3);
        rd_rst_n = 1'b1;
        tick(10);
        check("mid rst no rsp", 64'(rsp_hi - sb), 64'd0);
        check("mid rst cnt after", 64'(frame_cnt), 64'd0);

        // First frame after reset.
        fb = frames_seen;
        sb = rsp_hi;
        slave_word = 32'h0BADF00D;
        push(41'h0C312345678);
        wait_frames(fb + 1, 400, "post rst");
        tick(4);
        check("post rst cs_n low", 64'(last_cs_low), 64'd168);
        check("post rst mosi", 64'(last_mosi), 64'h0C300000000);
        check("post rst rsp pulses", 64'(rsp_hi - sb), 64'd1);
        check("post rst rsp_addr", 64'(bus.rsp_addr), 64'h0C3);
        check("post rst rsp_data", 64'(bus.rsp_data), 64'h0BADF00D);
        check("post rst frame_cnt", 64'(frame_cnt), 64'd1);
        check("sclk high with cs_n high", 64'(sclk_idle_hi), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
